// File: rtl/booth_r4_mult_seq_pkg.sv
// booth_r4_mult_seq_pkg: shared FSM encoding and Booth select bundle for the radix-4 multiplier
package booth_r4_mult_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  typedef struct packed {
    logic zero;
    logic neg;
    logic dbl;
  } booth_sel_t;
endpackage

// File: rtl/booth_r4_mult_seq_recode.sv
// booth_r4_mult_seq_recode: maps a 3-bit Booth group onto zero/negate/double selects
module booth_r4_mult_seq_recode
  import booth_r4_mult_seq_pkg::*;
(
  input  logic [2:0] grp,
  output booth_sel_t sel
);
  always_comb begin
    sel.zero = grp == 3'b000 || grp == 3'b111;
    sel.neg  = grp[2] && !sel.zero;
    sel.dbl  = grp == 3'b011 || grp == 3'b100;
  end
endmodule

// File: rtl/booth_r4_mult_seq.sv
// booth_r4_mult_seq: sequential radix-4 Booth multiplier, two multiplier bits per clock
module booth_r4_mult_seq
  import booth_r4_mult_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             overflow
);
  localparam int W2 = WIDTH + 2;
  localparam int ITER = WIDTH / 2 + 1;
  localparam int CW = $clog2(ITER);
  localparam int PW = 2 * W2 + 1;
  state_t state, state_n;
  booth_sel_t sel;
  logic [CW-1:0] count;
  logic [PW-1:0] p, p_n;
  logic [W2-1:0] m2, mag, term, sum;
  logic [2*WIDTH-1:0] prod;
  logic sgn, last, accept;
  booth_r4_mult_seq_recode u_recode (.grp(p[2:0]), .sel(sel));
  assign last = count == CW'(ITER - 1);
  assign accept = start && state != RUN;
  always_comb begin
    mag  = sel.zero ? '0 : sel.dbl ? {m2[W2-2:0], 1'b0} : m2;
    term = sel.neg ? ~mag : mag;
    sum  = p[PW-1 -: W2] + term + W2'(sel.neg);
    p_n  = {{2{sum[W2-1]}}, sum, p[W2:2]};
    prod = p_n[2*WIDTH:1];
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb state_n = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      p         <= '0;
      m2        <= '0;
      sgn       <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      overflow  <= 1'b0;
    end else if (accept) begin
      count <= '0;
      p     <= {{W2{1'b0}}, is_signed ? {{2{multiplier[WIDTH-1]}}, multiplier} : {2'b00, multiplier}, 1'b0};
      m2    <= is_signed ? {{2{multiplicand[WIDTH-1]}}, multiplicand} : {2'b00, multiplicand};
      sgn   <= is_signed;
    end else if (state == RUN) begin
      p     <= p_n;
      count <= count + 1'b1;
      if (last) begin
        result_lo <= prod[WIDTH-1:0];
        result_hi <= prod[2*WIDTH-1:WIDTH];
        overflow  <= sgn ? prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}} : prod[2*WIDTH-1:WIDTH] != '0;
      end
    end
  end
endmodule

// File: tb/tb_booth_r4_mult_seq.sv
// tb_booth_r4_mult_seq: directed 32-bit and randomised 8-bit checks against plain-arithmetic products
module tb_booth_r4_mult_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic start = 1'b0, sg = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic busy, done, ov;
  logic [31:0] lo, hi;
  logic start8 = 1'b0, sg8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic busy8, done8, ov8;
  logic [7:0] lo8, hi8;
  int checks = 0, errors = 0;

  booth_r4_mult_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(sg), .multiplicand(a), .multiplier(b),
    .busy(busy), .done(done), .result_lo(lo), .result_hi(hi), .overflow(ov)
  );
  booth_r4_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(sg8), .multiplicand(a8), .multiplier(b8),
    .busy(busy8), .done(done8), .result_lo(lo8), .result_hi(hi8), .overflow(ov8)
  );

  function automatic logic [63:0] mul32(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint px = s ? longint'($signed(x)) : longint'(x);
    longint py = s ? longint'($signed(y)) : longint'(y);
    return 64'(px * py);
  endfunction

  function automatic logic ovf32(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] p = mul32(x, y, s);
    longint ps = longint'($signed(p));
    return s ? (ps < -longint'(64'h8000_0000) || ps > longint'(64'h7FFF_FFFF)) : p > 64'hFFFF_FFFF;
  endfunction

  task automatic go32(input logic [31:0] x, input logic [31:0] y, input logic s);
    @(negedge clk);
    a = x; b = y; sg = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait32(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, ov, hi, lo} !== '0) begin
      errors++;
      $display("FAIL reset32: busy=%b done=%b ov=%b hi=%h lo=%h, want all zero", busy, done, ov, hi, lo);
    end
    checks++;
    if ({busy8, done8, ov8, hi8, lo8} !== '0) begin
      errors++;
      $display("FAIL reset8: busy=%b done=%b ov=%b hi=%h lo=%h, want all zero", busy8, done8, ov8, hi8, lo8);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [31:0] xs[3] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] ys[3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    logic ss[3] = '{1'b1, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 3; i++) begin
      go32(xs[i], ys[i], ss[i]);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_run[%0d]: busy=%b, want 1", i, busy);
      end
      wait32(lat);
      checks++;
      if (lat !== 17) begin
        errors++;
        $display("FAIL latency[%0d]: got %0d, want 17", i, lat);
      end
      checks++;
      if ({hi, lo} !== mul32(xs[i], ys[i], ss[i])) begin
        errors++;
        $display("FAIL product[%0d]: got %h_%h, want %h", i, hi, lo, mul32(xs[i], ys[i], ss[i]));
      end
      checks++;
      if (ov !== ovf32(xs[i], ys[i], ss[i])) begin
        errors++;
        $display("FAIL overflow[%0d]: got %b, want %b", i, ov, ovf32(xs[i], ys[i], ss[i]));
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || {hi, lo} !== mul32(xs[i], ys[i], ss[i])) begin
        errors++;
        $display("FAIL hold[%0d]: done=%b result=%h_%h, want done=0 and held product", i, done, hi, lo);
      end
    end
  endtask

  task automatic test_rst_mid_run;
    bit seen = 0;
    go32(32'd12345, 32'd678, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, ov, hi, lo} !== '0) begin
      errors++;
      $display("FAIL rst_mid_run: busy=%b done=%b ov=%b hi=%h lo=%h, want all zero", busy, done, ov, hi, lo);
    end
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_no_done: done seen after abort, want none");
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] xa = 32'hDEAD_BEEF, ya = 32'h0000_1234;
    logic [31:0] xc = 32'hFFFF_FF9C, yc = 32'h0000_0005;
    int lat;
    go32(xa, ya, 1'b1);
    repeat (3) @(negedge clk);
    a = 32'h1111_1111; b = 32'h2222_2222; sg = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait32(lat);
    checks++;
    if (lat !== 13) begin
      errors++;
      $display("FAIL ignore_latency: got %0d cycles after stray start, want 13", lat);
    end
    checks++;
    if ({hi, lo} !== mul32(xa, ya, 1'b1)) begin
      errors++;
      $display("FAIL ignore_product: got %h_%h, want %h", hi, lo, mul32(xa, ya, 1'b1));
    end
    a = xc; b = yc; sg = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait32(lat);
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL b2b_latency: got %0d, want 17", lat);
    end
    checks++;
    if ({hi, lo, ov} !== {mul32(xc, yc, 1'b1), ovf32(xc, yc, 1'b1)}) begin
      errors++;
      $display("FAIL b2b_product: got %h_%h ov=%b, want %h ov=%b", hi, lo, ov, mul32(xc, yc, 1'b1), ovf32(xc, yc, 1'b1));
    end
  endtask

  task automatic test_random8;
    for (int k = 0; k < 5000; k++) begin
      logic [7:0] x = 8'($urandom), y = 8'($urandom);
      logic s = 1'($urandom);
      int px = s ? int'($signed(x)) : int'(x);
      int py = s ? int'($signed(y)) : int'(y);
      int pr = px * py;
      logic [15:0] want = 16'(pr);
      logic want_ov = s ? (pr < -128 || pr > 127) : pr > 255;
      int lat = -1;
      @(negedge clk);
      a8 = x; b8 = y; sg8 = s; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      for (int n = 1; n <= 12; n++) begin
        @(negedge clk);
        if (done8) begin
          lat = n;
          break;
        end
      end
      checks++;
      if (lat !== 5 || {hi8, lo8} !== want || ov8 !== want_ov) begin
        errors++;
        $display("FAIL rand8[%0d]: %h*%h s=%b got lat=%0d p=%h ov=%b, want lat=5 p=%h ov=%b",
                 k, x, y, s, lat, {hi8, lo8}, ov8, want, want_ov);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_rst_mid_run;
    test_back_to_back;
    test_random8;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
